// File: rtl/press_classifier_pkg.sv
// Shared definitions for the press classifier: 3-bit state encoding and
// the matching FSM state type, reusable by benches and neighbouring blocks.
package press_classifier_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESS1    = 3'd1;
    localparam logic [2:0] ST_LONG_HOLD = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_PRESS2    = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        PRESS1    = ST_PRESS1,
        LONG_HOLD = ST_LONG_HOLD,
        GAP       = ST_GAP,
        PRESS2    = ST_PRESS2
    } state_t;

endpackage

// File: rtl/press_classifier.sv
// Button press classifier: turns a clean, synchronous button level into
// one-cycle short / long / double press pulses plus a registered busy flag.
// A single counter times both the hold (PRESS1) and the release gap (GAP);
// it restarts from zero on every state change and saturates instead of wrapping.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int LONG_COUNTS = 50_000_000,
    parameter int GAP_COUNTS  = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);

    localparam int CNT_MAX = (LONG_COUNTS > GAP_COUNTS) ? LONG_COUNTS : GAP_COUNTS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNTS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_COUNTS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CNT_MAX);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             short_s;
    logic             long_s;
    logic             double_s;

    // Next-state and pulse decode; release/re-press win over the timeouts.
    always_comb begin
        state_s  = state_r;
        short_s  = 1'b0;
        long_s   = 1'b0;
        double_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (button) begin
                    state_s = PRESS1;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS1: begin
                if (!button) begin
                    state_s = GAP;
                end else if (cnt_r == LONG_LAST) begin
                    state_s = LONG_HOLD;
                    long_s  = 1'b1;
                end else begin
                    state_s = PRESS1;
                end
            end
            LONG_HOLD: begin
                if (!button) begin
                    state_s = IDLE;
                end else begin
                    state_s = LONG_HOLD;
                end
            end
            GAP: begin
                if (button) begin
                    state_s = PRESS2;
                end else if (cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                    short_s = 1'b1;
                end else begin
                    state_s = GAP;
                end
            end
            PRESS2: begin
                if (!button) begin
                    state_s  = IDLE;
                    double_s = 1'b1;
                end else begin
                    state_s = PRESS2;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Counter update: clear on any transition, count only in timed states, saturate.
    always_comb begin
        cnt_s = cnt_r;
        if (state_s != state_r) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (((state_r == PRESS1) || (state_r == GAP)) && (cnt_r != CNT_LIMIT)) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, counter and registered outputs; busy reflects the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            short_press  <= short_s;
            long_press   <= long_s;
            double_press <= double_s;
            busy         <= (state_s != IDLE);
        end
    end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_COUNTS, default 50_000_000, meaning hold cycles (1 s at 50 MHz) that classify a long press.
REQ-002 SHALL have parameter GAP_COUNTS, default 12_500_000, meaning release-window cycles (250 ms) allowed before a second press.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning an asynchronous, active-high reset.
REQ-005 SHALL have port button, input, 1 bit, meaning the synchronised, debounced button level from the debounce stage, where 1 = pressed.
REQ-006 SHALL have port short_press, output, 1 bit, meaning a one-cycle pulse for a single short press.
REQ-007 SHALL have port long_press, output, 1 bit, meaning a one-cycle pulse when the hold reaches LONG_COUNTS.
REQ-008 SHALL have port double_press, output, 1 bit, meaning a one-cycle pulse for two presses within the gap window.
REQ-009 SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE.

Function
REQ-010 SHALL implement states IDLE, PRESS1, LONG_HOLD, GAP and PRESS2, with a single counter of width $clog2(max(LONG_COUNTS,GAP_COUNTS)+1).
REQ-011 SHALL clear the counter to 0 on every state transition and increment it by 1 on each cycle spent in PRESS1 or GAP; the counter SHALL never wrap.
REQ-012 In IDLE, button=1 SHALL move the FSM to PRESS1; button=0 SHALL keep it in IDLE.
REQ-013 In PRESS1, button=0 SHALL move the FSM to GAP; otherwise, when counter==LONG_COUNTS-1, the FSM SHALL move to LONG_HOLD and pulse long_press.
REQ-014 In LONG_HOLD, button=0 SHALL move the FSM to IDLE, and no further pulse SHALL be issued for that press.
REQ-015 In GAP, button=1 SHALL move the FSM to PRESS2; otherwise, when counter==GAP_COUNTS-1, the FSM SHALL move to IDLE and pulse short_press.
REQ-016 If button rises in GAP on the same cycle that counter==GAP_COUNTS-1, the rising button SHALL win: move to PRESS2, with no short_press.
REQ-017 If button falls in PRESS1 on the same cycle that counter==LONG_COUNTS-1, the release SHALL win: move to GAP, with no long_press.
REQ-018 In PRESS2, button=0 SHALL move the FSM to IDLE and pulse double_press; PRESS2 SHALL have no timeout, and a long hold there SHALL still yield only double_press on release.
REQ-019 All outputs SHALL be registered; each pulse SHALL be high for exactly one cycle, starting on the cycle after the deciding condition is sampled.
REQ-020 At most one of short_press, long_press and double_press SHALL be high in any cycle.
REQ-021 busy SHALL be registered and equal to (next state != IDLE), so it changes on the same cycle as the pulse outputs.

Reset
REQ-022 While reset=1, the block SHALL force state=IDLE, counter=0, and short_press, long_press, double_press and busy all 0, regardless of clk.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence with no pulse emitted.
REQ-024 After reset, if button is already 1 on the first clock, the block SHALL treat it as a new press (enter PRESS1).

Structure
REQ-025 The state encoding (3-bit localparams) SHALL reside in a shared package/include file, press_classifier_pkg, for reuse by the testbench.
REQ-026 The block SHALL be a single module with no sub-module; synchroniser and debounce remain separate upstream instances.
REQ-027 The module SHALL not instantiate its own synchroniser, because button is already synchronous to clk.

Verification (LONG_COUNTS=20, GAP_COUNTS=8, 20 ns clk)
REQ-028 Press 5 cycles, release, idle 20 cycles -> exactly one short_press pulse, 8 cycles after the release is sampled; busy falls on the same cycle.
REQ-029 Hold 30 cycles -> one long_press pulse after the 20th held cycle; no pulse on release; busy returns to 0 one cycle after release.
REQ-030 Press 4, release 3, press 4, release -> one double_press pulse, one cycle after the second release; no short_press.
REQ-031 Press 4, release exactly 8 cycles with the re-press on the final gap cycle -> FSM enters PRESS2, no short_press, and double_press follows the second release.
REQ-032 Assert reset during PRESS1 at counter=10 -> all outputs 0 immediately (asynchronously); no pulse after reset is released.
REQ-033 Chain the synchroniser and debounce stages ahead of press_classifier, then apply a bouncy 50 ns glitch followed by a clean 1 s hold at default parameters -> exactly one long_press pulse.
